// File: rtl/inst_buffer_pkg.sv
// Shared core constants for the instruction buffer between fetch and decode.
package inst_buffer_pkg;

   localparam int unsigned CORE_INST_WIDTH  = 32;
   localparam int unsigned CORE_PC_WIDTH    = 32;

   // Buffer depth sits next to the issue width so dual-issue can widen both together.
   localparam int unsigned SUPER_SCALAR_NUM = 1;
   localparam int unsigned IB_DEPTH         = 4;
   localparam int unsigned IB_DEPTH_BIT     = 2;

   // addi x0,x0,0
   localparam logic [CORE_INST_WIDTH-1:0] NOP_INST_VAL = 32'h0000_0013;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch / dispatch / execute side signals of the instruction buffer.
interface inst_buffer_if
   import inst_buffer_pkg::*;
#(
   parameter int unsigned INST_WIDTH = CORE_INST_WIDTH,
   parameter int unsigned PC_WIDTH   = CORE_PC_WIDTH,
   parameter int unsigned DEPTH_BIT  = IB_DEPTH_BIT
);

   logic                  ifu_instBuffer_vld;
   logic [INST_WIDTH-1:0] ifu_instBuffer_inst;
   logic [PC_WIDTH-1:0]   ifu_instBuffer_pc;
   logic                  instBuffer_ifu_rdy;
   logic                  dispatcher_instBuffer_stall;
   logic                  iex_instBuffer_flush;
   logic [INST_WIDTH-1:0] instBuffer_idu_inst_in;
   logic [PC_WIDTH-1:0]   instBuffer_idu_pc;
   logic                  instBuffer_idu_vld;
   logic [DEPTH_BIT:0]    instBuffer_cnt;

   // Pipeline side: fetch, dispatch and execute drive the buffer.
   modport master (
      output ifu_instBuffer_vld,
      output ifu_instBuffer_inst,
      output ifu_instBuffer_pc,
      input  instBuffer_ifu_rdy,
      output dispatcher_instBuffer_stall,
      output iex_instBuffer_flush,
      input  instBuffer_idu_inst_in,
      input  instBuffer_idu_pc,
      input  instBuffer_idu_vld,
      input  instBuffer_cnt
   );

   // Buffer side.
   modport slave (
      input  ifu_instBuffer_vld,
      input  ifu_instBuffer_inst,
      input  ifu_instBuffer_pc,
      output instBuffer_ifu_rdy,
      input  dispatcher_instBuffer_stall,
      input  iex_instBuffer_flush,
      output instBuffer_idu_inst_in,
      output instBuffer_idu_pc,
      output instBuffer_idu_vld,
      output instBuffer_cnt
   );

endinterface

// File: rtl/inst_buffer_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module inst_buffer_mem #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ADDR_BITS = 2,
   parameter int unsigned WIDTH     = 64
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_waddr,
   input  logic [WIDTH-1:0]     i_wdata,
   input  logic [ADDR_BITS-1:0] i_raddr,
   output logic [WIDTH-1:0]     o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Capture the pushed entry; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Head read is combinational so decode sees the entry in the cycle after its push.
   always_comb begin
      o_rdata = r_mem[i_raddr];
   end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and decode; presents a NOP when empty.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int unsigned               DEPTH      = IB_DEPTH,
   parameter int unsigned               DEPTH_BIT  = IB_DEPTH_BIT,
   parameter int unsigned               INST_WIDTH = CORE_INST_WIDTH,
   parameter int unsigned               PC_WIDTH   = CORE_PC_WIDTH,
   parameter logic [INST_WIDTH-1:0]     NOP_INST   = NOP_INST_VAL
) (
   input logic        clk,
   input logic        rst_n,
   inst_buffer_if.slave io_bus
);

   localparam int unsigned           EntryWidth = INST_WIDTH + PC_WIDTH;
   localparam logic [DEPTH_BIT-1:0] PtrOne     = DEPTH_BIT'(1);
   localparam logic [DEPTH_BIT:0]   CntOne     = (DEPTH_BIT + 1)'(1);
   localparam logic [DEPTH_BIT:0]   CntFull    = (DEPTH_BIT + 1)'(DEPTH);

   logic [DEPTH_BIT-1:0]  r_wr_ptr;
   logic [DEPTH_BIT-1:0]  r_rd_ptr;
   logic [DEPTH_BIT:0]    r_cnt;
   logic [DEPTH_BIT:0]    w_cnt_nxt;
   logic                  w_rdy;
   logic                  w_vld;
   logic                  w_push;
   logic                  w_pop;
   logic [EntryWidth-1:0] w_wdata;
   logic [EntryWidth-1:0] w_rdata;

   // Handshake decode; rdy and vld come from registered count only.
   always_comb begin
      w_rdy   = (r_cnt != CntFull);
      w_vld   = (r_cnt != '0);
      w_push  = io_bus.ifu_instBuffer_vld & w_rdy & ~io_bus.iex_instBuffer_flush;
      w_pop   = w_vld & ~io_bus.dispatcher_instBuffer_stall & ~io_bus.iex_instBuffer_flush;
      w_wdata = {io_bus.ifu_instBuffer_inst, io_bus.ifu_instBuffer_pc};
   end

   // Occupancy next-state; simultaneous push and pop cancel out.
   always_comb begin
      w_cnt_nxt = r_cnt;
      unique case ({w_push, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + CntOne;
         2'b01:   w_cnt_nxt = r_cnt - CntOne;
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   // Pointer and count state; flush overrides any push or pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (io_bus.iex_instBuffer_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrOne;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrOne;
         end
         r_cnt <= w_cnt_nxt;
      end
   end

   inst_buffer_mem #(
      .DEPTH     (DEPTH),
      .ADDR_BITS (DEPTH_BIT),
      .WIDTH     (EntryWidth)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // Head outputs, forced to a canonical NOP when empty so decode never sees stale bits.
   always_comb begin
      io_bus.instBuffer_ifu_rdy     = w_rdy;
      io_bus.instBuffer_idu_vld     = w_vld;
      io_bus.instBuffer_cnt         = r_cnt;
      io_bus.instBuffer_idu_inst_in = w_vld ? w_rdata[EntryWidth-1:PC_WIDTH] : NOP_INST;
      io_bus.instBuffer_idu_pc      = w_vld ? w_rdata[PC_WIDTH-1:0] : '0;
   end

   a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= CntFull)
      else $error("instruction buffer occupancy out of range");

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam int unsigned DEPTH = IB_DEPTH;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [31:0] m_inst [$];
   logic [31:0] m_pc   [$];

   inst_buffer_if bus ();

   inst_buffer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a plain FIFO of at most DEPTH entries.
   task automatic model_step(input bit vld, input logic [31:0] inst, input logic [31:0] pc,
                             input bit stall, input bit flush);
      int n;
      bit do_push;
      bit do_pop;
      n       = m_inst.size();
      do_push = vld && (n < int'(DEPTH));
      do_pop  = (n > 0) && !stall;
      if (flush) begin
         m_inst.delete();
         m_pc.delete();
      end else begin
         if (do_pop) begin
            void'(m_inst.pop_front());
            void'(m_pc.pop_front());
         end
         if (do_push) begin
            m_inst.push_back(inst);
            m_pc.push_back(pc);
         end
      end
   endtask

   function automatic logic [31:0] exp_inst();
      return (m_inst.size() > 0) ? m_inst[0] : NOP;
   endfunction

   function automatic logic [31:0] exp_pc();
      return (m_pc.size() > 0) ? m_pc[0] : 32'h0;
   endfunction

   // Drive one clock of stimulus from a negedge, update the model, return at next negedge.
   task automatic cycle(input bit vld, input logic [31:0] inst, input logic [31:0] pc,
                        input bit stall, input bit flush);
      bus.ifu_instBuffer_vld          = vld;
      bus.ifu_instBuffer_inst         = inst;
      bus.ifu_instBuffer_pc           = pc;
      bus.dispatcher_instBuffer_stall = stall;
      bus.iex_instBuffer_flush        = flush;
      @(posedge clk);
      model_step(vld, inst, pc, stall, flush);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.ifu_instBuffer_vld          = 1'b0;
      bus.ifu_instBuffer_inst         = 32'h0;
      bus.ifu_instBuffer_pc           = 32'h0;
      bus.dispatcher_instBuffer_stall = 1'b0;
      bus.iex_instBuffer_flush        = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.instBuffer_idu_vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_vld: got %b want 0", bus.instBuffer_idu_vld);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.instBuffer_idu_vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_vld: got %b want 0", bus.instBuffer_idu_vld);
      end
      total++;
      if (bus.instBuffer_idu_inst_in !== NOP) begin
         bad++;
         $display("FAIL reset_inst: got %h want %h", bus.instBuffer_idu_inst_in, NOP);
      end
      total++;
      if (bus.instBuffer_idu_pc !== 32'h0) begin
         bad++;
         $display("FAIL reset_pc: got %h want 0", bus.instBuffer_idu_pc);
      end
      total++;
      if (bus.instBuffer_ifu_rdy !== 1'b1) begin
         bad++;
         $display("FAIL reset_rdy: got %b want 1", bus.instBuffer_ifu_rdy);
      end
      total++;
      if (bus.instBuffer_cnt !== 3'd0) begin
         bad++;
         $display("FAIL reset_cnt: got %0d want 0", bus.instBuffer_cnt);
      end
   endtask

   task automatic test_single_push();
      cycle(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
      total++;
      if (bus.instBuffer_idu_vld !== 1'b1 || bus.instBuffer_idu_inst_in !== 32'h0050_0093 ||
          bus.instBuffer_idu_pc !== 32'h100) begin
         bad++;
         $display("FAIL single_head: got vld=%b inst=%h pc=%h want 1 00500093 100",
                  bus.instBuffer_idu_vld, bus.instBuffer_idu_inst_in, bus.instBuffer_idu_pc);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if (bus.instBuffer_cnt !== 3'd0 || bus.instBuffer_idu_vld !== 1'b0 ||
          bus.instBuffer_idu_inst_in !== NOP) begin
         bad++;
         $display("FAIL single_pop: got cnt=%0d vld=%b inst=%h want 0 0 %h",
                  bus.instBuffer_cnt, bus.instBuffer_idu_vld, bus.instBuffer_idu_inst_in, NOP);
      end
   endtask

   task automatic test_fill_stall();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, $urandom, 32'(4 * i), 1'b1, 1'b0);
         total++;
         if (bus.instBuffer_idu_pc !== 32'h0 || bus.instBuffer_idu_inst_in !== exp_inst()) begin
            bad++;
            $display("FAIL fill_head[%0d]: got pc=%h inst=%h want 0 %h", i,
                     bus.instBuffer_idu_pc, bus.instBuffer_idu_inst_in, exp_inst());
         end
      end
      total++;
      if (bus.instBuffer_cnt !== 3'd4 || bus.instBuffer_ifu_rdy !== 1'b0) begin
         bad++;
         $display("FAIL fill_full: got cnt=%0d rdy=%b want 4 0",
                  bus.instBuffer_cnt, bus.instBuffer_ifu_rdy);
      end
      cycle(1'b1, $urandom, 32'h10, 1'b1, 1'b0);
      total++;
      if (bus.instBuffer_cnt !== 3'd4 || bus.instBuffer_idu_pc !== 32'h0) begin
         bad++;
         $display("FAIL fill_overflow: got cnt=%0d pc=%h want 4 0",
                  bus.instBuffer_cnt, bus.instBuffer_idu_pc);
      end
   endtask

   task automatic test_drain_wrap();
      logic [31:0] seen [$];
      logic [31:0] next_pc;
      bit          pv;
      next_pc = 32'h10;
      for (int cyc = 0; cyc < 40 && seen.size() < 8; cyc++) begin
         total++;
         if (bus.instBuffer_idu_pc !== exp_pc() || bus.instBuffer_ifu_rdy !==
             (m_pc.size() < int'(DEPTH))) begin
            bad++;
            $display("FAIL drain_head: got pc=%h rdy=%b want %h %b", bus.instBuffer_idu_pc,
                     bus.instBuffer_ifu_rdy, exp_pc(), (m_pc.size() < int'(DEPTH)));
         end
         if (bus.instBuffer_idu_vld === 1'b1) seen.push_back(bus.instBuffer_idu_pc);
         pv = (bus.instBuffer_ifu_rdy === 1'b1) && (next_pc <= 32'h1C);
         cycle(pv, $urandom, next_pc, 1'b0, 1'b0);
         if (pv) next_pc += 32'h4;
      end
      total++;
      if (seen.size() != 8) begin
         bad++;
         $display("FAIL drain_count: got %0d want 8", seen.size());
      end
      for (int i = 0; i < seen.size(); i++) begin
         total++;
         if (seen[i] !== 32'(4 * i)) begin
            bad++;
            $display("FAIL drain_order[%0d]: got %h want %h", i, seen[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 32'(32'h20 + 4 * i), 1'b1, 1'b0);
      total++;
      if (bus.instBuffer_cnt !== 3'd3) begin
         bad++;
         $display("FAIL flush_pre_cnt: got %0d want 3", bus.instBuffer_cnt);
      end
      cycle(1'b1, $urandom, 32'h40, 1'b0, 1'b1);
      total++;
      if (bus.instBuffer_cnt !== 3'd0 || bus.instBuffer_idu_vld !== 1'b0 ||
          bus.instBuffer_idu_inst_in !== NOP || bus.instBuffer_idu_pc !== 32'h0) begin
         bad++;
         $display("FAIL flush_empty: got cnt=%0d vld=%b inst=%h pc=%h want 0 0 %h 0",
                  bus.instBuffer_cnt, bus.instBuffer_idu_vld, bus.instBuffer_idu_inst_in,
                  bus.instBuffer_idu_pc, NOP);
      end
      cycle(1'b1, 32'h1234_5678, 32'h80, 1'b1, 1'b0);
      total++;
      if (bus.instBuffer_idu_vld !== 1'b1 || bus.instBuffer_idu_pc !== 32'h80 ||
          bus.instBuffer_idu_inst_in !== 32'h1234_5678 || bus.instBuffer_cnt !== 3'd1) begin
         bad++;
         $display("FAIL flush_refill: got vld=%b pc=%h inst=%h cnt=%0d want 1 80 12345678 1",
                  bus.instBuffer_idu_vld, bus.instBuffer_idu_pc, bus.instBuffer_idu_inst_in,
                  bus.instBuffer_cnt);
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b1, $urandom, 32'h90, 1'b1, 1'b0);
      total++;
      if (bus.instBuffer_cnt !== 3'd2) begin
         bad++;
         $display("FAIL areset_pre_cnt: got %0d want 2", bus.instBuffer_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      m_inst.delete();
      m_pc.delete();
      total++;
      if (bus.instBuffer_cnt !== 3'd0 || bus.instBuffer_idu_vld !== 1'b0 ||
          bus.instBuffer_idu_inst_in !== NOP || bus.instBuffer_ifu_rdy !== 1'b1) begin
         bad++;
         $display("FAIL areset_now: got cnt=%0d vld=%b inst=%h rdy=%b want 0 0 %h 1",
                  bus.instBuffer_cnt, bus.instBuffer_idu_vld, bus.instBuffer_idu_inst_in,
                  bus.instBuffer_ifu_rdy, NOP);
      end
      #1 rst_n = 1'b1;
      cycle(1'b1, 32'hCAFE_0013, 32'hA0, 1'b1, 1'b0);
      total++;
      if (bus.instBuffer_cnt !== 3'd1 || bus.instBuffer_idu_pc !== 32'hA0) begin
         bad++;
         $display("FAIL areset_first_push: got cnt=%0d pc=%h want 1 a0",
                  bus.instBuffer_cnt, bus.instBuffer_idu_pc);
      end
   endtask

   task automatic test_random();
      bit          v;
      bit          s;
      bit          f;
      logic [31:0] pc;
      pc = 32'h1000;
      for (int cyc = 0; cyc < 400; cyc++) begin
         total++;
         if (bus.instBuffer_idu_vld !== (m_inst.size() > 0) ||
             bus.instBuffer_idu_inst_in !== exp_inst() || bus.instBuffer_idu_pc !== exp_pc() ||
             bus.instBuffer_ifu_rdy !== (m_inst.size() < int'(DEPTH)) ||
             int'(bus.instBuffer_cnt) != m_inst.size()) begin
            bad++;
            $display("FAIL random[%0d]: got vld=%b inst=%h pc=%h rdy=%b cnt=%0d want cnt=%0d inst=%h pc=%h",
                     cyc, bus.instBuffer_idu_vld, bus.instBuffer_idu_inst_in, bus.instBuffer_idu_pc,
                     bus.instBuffer_ifu_rdy, bus.instBuffer_cnt, m_inst.size(), exp_inst(),
                     exp_pc());
         end
         v = ($urandom_range(0, 9) < 7);
         s = ($urandom_range(0, 9) < 4);
         f = ($urandom_range(0, 19) == 0);
         cycle(v, $urandom, pc, s, f);
         pc += 32'h4;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single_push();
      test_fill_stall();
      test_drain_wrap();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Circular FIFO between instruction fetch and instruction decode.
- Holds fetched instruction/PC pairs and presents the oldest one to decode.
- Holds the head while dispatch stalls (load-use hazard, WFI).
- Discards all contents on a branch/jump redirect from execute.
- When empty, presents a canonical NOP so downstream decode never sees stale bits.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- DEPTH_BIT, 2, log2(DEPTH); pointer width.
- INST_WIDTH, 32, instruction width (matches `INST_WIDTH).
- PC_WIDTH, 32, program counter width.
- NOP_INST, 32'h0000_0013, value presented when empty (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_instBuffer_vld  in  1  fetch presents a valid instruction this cycle.
- ifu_instBuffer_inst  in  INST_WIDTH  fetched instruction.
- ifu_instBuffer_pc  in  PC_WIDTH  PC of the fetched instruction.
- instBuffer_ifu_rdy  out  1  buffer accepts a push this cycle.
- dispatcher_instBuffer_stall  in  1  decode cannot consume the head (stall or WFI).
- iex_instBuffer_flush  in  1  redirect; discard every entry.
- instBuffer_idu_inst_in  out  INST_WIDTH  head instruction, or NOP_INST when empty.
- instBuffer_idu_pc  out  PC_WIDTH  head PC, or 0 when empty.
- instBuffer_idu_vld  out  1  head is a real instruction.
- instBuffer_cnt  out  DEPTH_BIT+1  occupancy, for performance counters and debug.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - Storage contents are don't-care and are not reset.
  - Outputs during reset: vld=0, inst=NOP_INST, pc=0, rdy=1, cnt=0.
- rdy = (cnt != DEPTH). It depends only on registered state; no combinational path from stall to rdy.
- push = ifu_instBuffer_vld & rdy & ~flush.
  - Writes inst and pc at wr_ptr; wr_ptr increments, wrapping modulo DEPTH.
- pop = instBuffer_idu_vld & ~dispatcher_instBuffer_stall & ~flush.
  - rd_ptr increments, wrapping modulo DEPTH.
- Count update: push only gives cnt+1; pop only gives cnt-1; push and pop together leave cnt unchanged.
- Full (cnt=DEPTH): rdy=0, no push. A pop in the same cycle frees a slot, but rdy rises only in the next cycle.
- Empty (cnt=0): vld=0 and outputs are NOP_INST and pc=0. A push becomes visible at the head the following cycle; there is no same-cycle bypass, so fetch-to-decode latency is 1 cycle.
- Head outputs are a combinational read of the entry at rd_ptr, gated by vld = (cnt != 0).
- Flush has priority over push and pop. Next cycle: cnt=0, rd_ptr=wr_ptr=0, vld=0. A fetch push in the flush cycle is dropped; fetch re-issues from the redirect PC.
- Stall with vld=1 keeps rd_ptr, so the head stays stable for as many cycles as stall lasts. Pushes continue until full.
- Stall while empty has no effect.
- Reset asserted mid-operation empties the buffer immediately (asynchronous). The first push is accepted on the first rising edge after rst_n deasserts.
- Pointer wrap: wr_ptr and rd_ptr are DEPTH_BIT wide and wrap naturally. Full/empty are decided only by cnt, not by pointer equality.
- No overflow or underflow is possible by construction. An assertion checks 0 <= cnt <= DEPTH every cycle.

Decomposition:
- Shared package/defines: NOP_INST, INST_WIDTH, PC_WIDTH, and the buffer DEPTH/DEPTH_BIT constants. DEPTH is placed next to `SUPER_SCALAR_NUM for future dual-issue widening.
- One natural sub-module, inst_buffer_mem: DEPTH x (INST_WIDTH+PC_WIDTH) register array with one write port and one asynchronous read port, no reset.
- Pointer/count control stays in the top module.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high → vld=0, inst=32'h00000013, pc=0, rdy=1, cnt=0.
- Single push: push inst=32'h00500093, pc=0x100 → next cycle vld=1, inst=32'h00500093, pc=0x100. Stall=0 → popped; following cycle cnt=0, vld=0.
- Fill under stall: stall=1, push 4 instructions at pc 0x0,0x4,0x8,0xC on consecutive cycles → cnt=4, rdy=0. A 5th push (pc 0x10) is ignored; the head stays pc 0x0 throughout.
- Drain with wrap: from full, release stall while pushing pc 0x10..0x1C as rdy permits → decode sees PCs 0x0,0x4,...,0x1C in order with no gaps or duplicates. Pointers wrap past index 3 correctly.
- Flush with concurrent push/pop: cnt=3, assert flush with ifu_vld=1 (pc 0x40) and stall=0 → next cycle cnt=0, vld=0. Pc 0x40 is never presented; a push of pc 0x80 next cycle appears as the head one cycle later.
- Async reset mid-stream: cnt=2, drop rst_n between clock edges → cnt=0, vld=0, inst=NOP immediately, without waiting for a clock edge.
